// File: rtl/bt_codes.sv
// Shared Bluetooth status codes: ASCII constants, FSM encodings, status
// payload and the frame byte builder. Also imported by the RX command decoder.
package bt_codes;

  localparam logic [7:0] ASC_A  = 8'h41;  // motor up
  localparam logic [7:0] ASC_B  = 8'h42;  // motor down
  localparam logic [7:0] ASC_C  = 8'h43;  // motor stop
  localparam logic [7:0] ASC_E  = 8'h45;  // illegal motor command
  localparam logic [7:0] ASC_J  = 8'h4A;  // lamp on
  localparam logic [7:0] ASC_K  = 8'h4B;  // lamp off
  localparam logic [7:0] ASC_S  = 8'h53;  // frame header
  localparam logic [7:0] ASC_LF = 8'h0A;  // frame trailer

  localparam int unsigned FRAME_BYTES = 4;

  // Line-level serializer states
  typedef enum logic [1:0] {
    LN_IDLE  = 2'd0,
    LN_START = 2'd1,
    LN_DATA  = 2'd2,
    LN_STOP  = 2'd3
  } line_state_e;

  // Frame sequencer states
  typedef enum logic {
    FRM_IDLE = 1'b0,
    FRM_SEND = 1'b1
  } frm_state_e;

  // Snapshot of the reported controls
  typedef struct packed {
    logic izq;
    logic der;
    logic on_off_l;
  } status_t;

  function automatic logic [7:0] motor_code(input logic izq, input logic der);
    logic [7:0] code;
    unique case ({izq, der})
      2'b00:   code = ASC_C;
      2'b01:   code = ASC_A;
      2'b10:   code = ASC_B;
      default: code = ASC_E;
    endcase
    return code;
  endfunction

  // Byte idx of the status frame 'S', motor, lamp, LF
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input status_t st);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = ASC_S;
      2'd1:    b = motor_code(st.izq, st.der);
      2'd2:    b = st.on_off_l ? ASC_J : ASC_K;
      default: b = ASC_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bt_status_tx_if.sv
// Status reporter bus: control inputs, report request and the serial line.
//   izq, der, on_off_l : decoded motor/lamp controls
//   req                : single-cycle report request
//   tx                 : UART line, idle high
//   busy, frame_done   : frame in progress / end-of-frame pulse
interface bt_status_tx_if;
  logic izq;
  logic der;
  logic on_off_l;
  logic req;
  logic tx;
  logic busy;
  logic frame_done;

  modport master (
    output izq, der, on_off_l, req,
    input  tx, busy, frame_done
  );

  modport slave (
    input  izq, der, on_off_l, req,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/bt_tx_serializer.sv
// Byte-wide 8N1 transmitter with baud counter.
//   clk, rst : clock, synchronous active-high reset
//   load     : accept data; only honoured while ready is high
//   data     : byte to send, LSB first
//   ready    : high in idle and in the last cycle of a stop bit, so a
//              following byte can be chained with no idle gap
//   tx       : serial line, idle high
module bt_tx_serializer
  import bt_codes::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  line_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_d, ready_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LN_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
      ready   <= ready_d;
    end
  end

  // Next state; tx and ready are derived from the next state so they register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;

    unique case (state_q)
      LN_IDLE: begin
        cnt_d = '0;
        if (load) begin
          state_d = LN_START;
          sh_d    = data;
        end
      end
      LN_START: begin
        if (bit_end) begin
          state_d = LN_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      LN_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = LN_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      LN_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (load) begin
            state_d = LN_START;
            sh_d    = data;
          end else begin
            state_d = LN_IDLE;
          end
        end
      end
      default: state_d = LN_IDLE;
    endcase

    unique case (state_d)
      LN_START: tx_d = 1'b0;
      LN_DATA:  tx_d = sh_d[0];
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == LN_IDLE) || ((state_d == LN_STOP) && (cnt_d == CNT_LAST));
  end

endmodule

// File: rtl/bt_status_tx.sv
// Bluetooth status reporter: sends 'S', motor, lamp, LF as 8N1 whenever the
// controls differ from the last report or a report is requested.
//   clkf, rst : clock, synchronous active-high reset
//   bus       : slave side of bt_status_tx_if (controls, req, tx, busy,
//               frame_done)
module bt_status_tx
  import bt_codes::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic           clkf,
  input  logic           rst,
  bt_status_tx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  frm_state_e state_q, state_d;
  logic [1:0] byte_q, byte_d;
  logic       pend_q, pend_d;
  status_t    last_q, last_d;
  status_t    snap_q, snap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  status_t    live;
  logic       load_c;
  logic [7:0] data_c;
  logic       ser_ready;

  assign live = {bus.izq, bus.der, bus.on_off_l};

  bt_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk   (clkf),
    .rst   (rst),
    .load  (load_c),
    .data  (data_c),
    .ready (ser_ready),
    .tx    (bus.tx)
  );

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  // Sequencer registers
  always_ff @(posedge clkf) begin
    if (rst) begin
      state_q <= FRM_IDLE;
      byte_q  <= '0;
      pend_q  <= 1'b0;
      last_q  <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame trigger and byte sequencing
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    pend_d  = pend_q | bus.req;
    last_d  = last_q;
    snap_d  = snap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    data_c  = frame_byte(byte_q + 2'd1, snap_q);

    unique case (state_q)
      FRM_IDLE: begin
        // Starting a frame consumes any pending request, including one this cycle
        if (pend_q || bus.req || (live != last_q)) begin
          state_d = FRM_SEND;
          snap_d  = live;
          last_d  = live;
          byte_d  = '0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          load_c  = 1'b1;
          data_c  = frame_byte(2'd0, live);
        end
      end
      FRM_SEND: begin
        if (ser_ready) begin
          if (byte_q != 2'(FRAME_BYTES - 1)) begin
            byte_d = byte_q + 2'd1;
            load_c = 1'b1;
          end else begin
            state_d = FRM_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = FRM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bt_status_tx.sv
// Directed bench for bt_status_tx at 10 clocks per bit (400-cycle frames).
module tb_bt_status_tx;

  logic clkf;
  logic rst;
  int   n_vec;
  int   n_err;

  bt_status_tx_if bus_if ();

  bt_status_tx #(
    .CLK_HZ (1000),
    .BAUD   (100)
  ) dut (
    .clkf (clkf),
    .rst  (rst),
    .bus  (bus_if)
  );

  initial clkf = 1'b0;
  always #5 clkf = ~clkf;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkf);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Poll for the start bit, looking at the current cycle first
  task automatic wait_fall(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (bus_if.tx == 1'b0) begin
        seen = 1'b1;
        break;
      end
      if (i < budget) step(1);
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
  endtask

  // Decode one frame at bit centres; ends on the cycle frame_done is due
  task automatic recv_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input int budget);
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    exp_b[3] = e3;
    wait_fall(tag, budget);
    for (int k = 0; k < 4; k++) begin
      step(5);
      check($sformatf("%s_b%0d_startbit", tag, k), 32'(bus_if.tx), 32'd0);
      got = '0;
      for (int i = 0; i < 8; i++) begin
        step(10);
        got[i] = bus_if.tx;
      end
      check($sformatf("%s_b%0d_data", tag, k), 32'(got), 32'(exp_b[k]));
      step(10);
      check($sformatf("%s_b%0d_stopbit", tag, k), 32'(bus_if.tx), 32'd1);
      check($sformatf("%s_b%0d_busy", tag, k), 32'(bus_if.busy), 32'd1);
      check($sformatf("%s_b%0d_nodone", tag, k), 32'(bus_if.frame_done), 32'd0);
      step(5);
    end
    check({tag, "_done"}, 32'(bus_if.frame_done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
  endtask

  // Count cycles with any line or status activity
  task automatic no_frame(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus_if.tx == 1'b0 || bus_if.busy || bus_if.frame_done) act++;
    end
    check(tag, 32'(act), 32'd0);
  endtask

  task automatic pulse_req();
    bus_if.req = 1'b1;
    step(1);
    bus_if.req = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.izq = 1'b0;
    bus_if.der = 1'b0;
    bus_if.on_off_l = 1'b0;
    bus_if.req = 1'b0;
    step(3);
    check("rst_tx", 32'(bus_if.tx), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.frame_done), 32'd0);
    rst = 1'b0;
    no_frame("idle_000", 1000);

    // Motor up: S A K LF
    bus_if.der = 1'b1;
    recv_frame("up", 8'h53, 8'h41, 8'h4B, 8'h0A, 1);
    step(1);
    check("up_done_pulse", 32'(bus_if.frame_done), 32'd0);
    no_frame("up_quiet", 50);

    // Request repeats status; lamp change and two reqs during it give one more frame
    pulse_req();
    fork
      recv_frame("rep", 8'h53, 8'h41, 8'h4B, 8'h0A, 1);
      begin
        step(50);
        bus_if.on_off_l = 1'b1;
        step(30);
        pulse_req();
        step(100);
        pulse_req();
      end
    join
    recv_frame("lamp", 8'h53, 8'h41, 8'h4A, 8'h0A, 1);
    no_frame("one_extra", 600);

    // Illegal motor combination
    bus_if.izq = 1'b1;
    recv_frame("illegal", 8'h53, 8'h45, 8'h4A, 8'h0A, 1);
    no_frame("ill_quiet", 20);

    // Request with unchanged inputs
    pulse_req();
    recv_frame("req_same", 8'h53, 8'h45, 8'h4A, 8'h0A, 1);
    no_frame("req_quiet", 20);

    // Motor stop
    bus_if.izq = 1'b0;
    bus_if.der = 1'b0;
    recv_frame("stop", 8'h53, 8'h43, 8'h4A, 8'h0A, 1);
    no_frame("stop_quiet", 20);

    // Change and request in the same cycle: one frame only
    bus_if.izq = 1'b1;
    bus_if.on_off_l = 1'b0;
    pulse_req();
    recv_frame("down", 8'h53, 8'h42, 8'h4B, 8'h0A, 1);
    no_frame("down_single", 500);

    // Reset mid-frame, at byte 1 bit 4 of 'B' (a 0 on the line)
    pulse_req();
    wait_fall("trunc", 1);
    step(150);
    check("trunc_pre_tx", 32'(bus_if.tx), 32'd0);
    rst = 1'b1;
    step(1);
    check("trunc_tx", 32'(bus_if.tx), 32'd1);
    check("trunc_busy", 32'(bus_if.busy), 32'd0);
    check("trunc_done", 32'(bus_if.frame_done), 32'd0);
    step(1);
    rst = 1'b0;
    recv_frame("post_rst", 8'h53, 8'h42, 8'h4B, 8'h0A, 1);
    no_frame("post_rst_quiet", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
